// File: rtl/sys_cmd_master_if.sv
// ----------------------------------------------------------------------------
// sys_cmd_master_if
//   Bundles the handshake and byte buses of the UART command initiator.
//
//   Command side : CMD_VLD/CMD_RDY handshake with CMD_TYPE, CMD_ADDR,
//                  CMD_DATA_A, CMD_DATA_B, CMD_FUNC payload.
//   TX side      : TX_P_DATA/TX_P_VLD toward the UART transmitter, TX_READY back.
//   RX side      : RX_P_DATA/RX_P_VLD one-cycle byte pulses from the receiver.
//   Response     : RSP_DATA, RSP_VLD, RSP_TIMEOUT, BUSY.
//
//   modport master : the command initiator (drives CMD_RDY, TX_*, RSP_*, BUSY).
//   modport slave  : its environment (host logic, UART blocks or a bench).
// ----------------------------------------------------------------------------
interface sys_cmd_master_if #(
  parameter int FRAME_WIDTH         = 8,
  parameter int REG_FILE_ADDR_WIDTH = 4,
  parameter int ALU_FUNC_WIDTH      = 4,
  parameter int ALU_DATA_WIDTH      = 16
) ();

  logic                           CMD_VLD;
  logic                           CMD_RDY;
  logic [1:0]                     CMD_TYPE;
  logic [REG_FILE_ADDR_WIDTH-1:0] CMD_ADDR;
  logic [FRAME_WIDTH-1:0]         CMD_DATA_A;
  logic [FRAME_WIDTH-1:0]         CMD_DATA_B;
  logic [ALU_FUNC_WIDTH-1:0]      CMD_FUNC;

  logic [FRAME_WIDTH-1:0]         TX_P_DATA;
  logic                           TX_P_VLD;
  logic                           TX_READY;

  logic [FRAME_WIDTH-1:0]         RX_P_DATA;
  logic                           RX_P_VLD;

  logic [ALU_DATA_WIDTH-1:0]      RSP_DATA;
  logic                           RSP_VLD;
  logic                           RSP_TIMEOUT;
  logic                           BUSY;

  modport master (
    input  CMD_VLD, CMD_TYPE, CMD_ADDR, CMD_DATA_A, CMD_DATA_B, CMD_FUNC,
    input  TX_READY, RX_P_DATA, RX_P_VLD,
    output CMD_RDY, TX_P_DATA, TX_P_VLD,
    output RSP_DATA, RSP_VLD, RSP_TIMEOUT, BUSY
  );

  modport slave (
    output CMD_VLD, CMD_TYPE, CMD_ADDR, CMD_DATA_A, CMD_DATA_B, CMD_FUNC,
    output TX_READY, RX_P_DATA, RX_P_VLD,
    input  CMD_RDY, TX_P_DATA, TX_P_VLD,
    input  RSP_DATA, RSP_VLD, RSP_TIMEOUT, BUSY
  );

endinterface

// File: rtl/sys_cmd_master.sv
// ----------------------------------------------------------------------------
// sys_cmd_master
//   Host-side command initiator for the UART register-file/ALU system.
//   Accepts one parallel command, serialises it into the byte-frame protocol
//   toward a UART transmitter, then assembles the response bytes coming back
//   from a UART receiver.
//
//   Frames:  write  AA addr data      (no response)
//            read   BB addr           (1 response byte)
//            ALU    CC A B func       (2 response bytes, LSB first)
//            ALU    DD func           (2 response bytes, LSB first)
//
//   Ports:
//     CLK, RST_n : clock and asynchronous active-low reset
//     bus        : sys_cmd_master_if.master (command, TX, RX, response)
// ----------------------------------------------------------------------------
module sys_cmd_master #(
  parameter int FRAME_WIDTH         = 8,
  parameter int REG_FILE_ADDR_WIDTH = 4,
  parameter int ALU_FUNC_WIDTH      = 4,
  parameter int ALU_DATA_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES      = 4096
) (
  input logic              CLK,
  input logic              RST_n,
  sys_cmd_master_if.master bus
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_RSP,
    S_DONE,
    S_ABORT
  } state_e;

  typedef enum logic [1:0] {
    CMD_WRITE   = 2'd0,
    CMD_READ    = 2'd1,
    CMD_ALU_OP  = 2'd2,
    CMD_ALU_NOP = 2'd3
  } cmd_type_e;

  state_e                         state_q, state_d;
  logic [1:0]                     idx_q, idx_d;
  cmd_type_e                      type_q, type_d;
  logic [REG_FILE_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [FRAME_WIDTH-1:0]         data_a_q, data_a_d;
  logic [FRAME_WIDTH-1:0]         data_b_q, data_b_d;
  logic [ALU_FUNC_WIDTH-1:0]      func_q, func_d;
  logic [1:0]                     rx_cnt_q, rx_cnt_d;
  logic [FRAME_WIDTH-1:0]         rx_byte0_q, rx_byte0_d;
  logic [ALU_DATA_WIDTH-1:0]      rsp_data_q, rsp_data_d;
  logic [TMO_W-1:0]               tmo_cnt_q, tmo_cnt_d;

  // Frame decode of the registered command.
  logic [FRAME_WIDTH-1:0] frame_byte;
  logic [1:0]             last_idx;
  logic [1:0]             rsp_cnt;
  logic [FRAME_WIDTH-1:0] addr_ext;
  logic [FRAME_WIDTH-1:0] func_ext;

  assign addr_ext = FRAME_WIDTH'(addr_q);
  assign func_ext = FRAME_WIDTH'(func_q);

  // NOTE: every variable assigned in an always_comb gets a default first, so
  // no path through the case arms can leave it unassigned and infer a latch.
  always_comb begin
    frame_byte = '0;
    last_idx   = '0;
    rsp_cnt    = '0;
    case (type_q)
      CMD_WRITE: begin
        last_idx = 2'd2;
        rsp_cnt  = 2'd0;
        case (idx_q)
          2'd0:    frame_byte = 8'hAA;
          2'd1:    frame_byte = addr_ext;
          default: frame_byte = data_a_q;
        endcase
      end
      CMD_READ: begin
        last_idx   = 2'd1;
        rsp_cnt    = 2'd1;
        frame_byte = (idx_q == 2'd0) ? 8'hBB : addr_ext;
      end
      CMD_ALU_OP: begin
        last_idx = 2'd3;
        rsp_cnt  = 2'd2;
        case (idx_q)
          2'd0:    frame_byte = 8'hCC;
          2'd1:    frame_byte = data_a_q;
          2'd2:    frame_byte = data_b_q;
          default: frame_byte = func_ext;
        endcase
      end
      default: begin  // CMD_ALU_NOP
        last_idx   = 2'd1;
        rsp_cnt    = 2'd2;
        frame_byte = (idx_q == 2'd0) ? 8'hDD : func_ext;
      end
    endcase
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    type_d     = type_q;
    addr_d     = addr_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    func_d     = func_q;
    rx_cnt_d   = rx_cnt_q;
    rx_byte0_d = rx_byte0_q;
    rsp_data_d = rsp_data_q;
    tmo_cnt_d  = tmo_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.CMD_VLD) begin
          // Snapshot the request so the host may change its inputs freely.
          type_d   = cmd_type_e'(bus.CMD_TYPE);
          addr_d   = bus.CMD_ADDR;
          data_a_d = bus.CMD_DATA_A;
          data_b_d = bus.CMD_DATA_B;
          func_d   = bus.CMD_FUNC;
          idx_d    = '0;
          rx_cnt_d = '0;
          state_d  = S_SEND;
        end
      end

      S_SEND: begin
        if (bus.TX_READY) begin
          if (idx_q == last_idx) begin
            // RX bytes arriving in this cycle are ignored: the receive
            // window only opens once the FSM sits in WAIT_RSP.
            if (rsp_cnt == 2'd0) begin
              rsp_data_d = '0;
              state_d    = S_DONE;
            end else begin
              rx_cnt_d  = '0;
              tmo_cnt_d = '0;
              state_d   = S_WAIT_RSP;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end

      S_WAIT_RSP: begin
        if (bus.RX_P_VLD) begin
          tmo_cnt_d = '0;
          if (rx_cnt_q == 2'(rsp_cnt - 2'd1)) begin
            // Final byte: read responses are one byte, ALU responses are
            // the earlier byte as LSB and this byte as MSB.
            if (type_q == CMD_READ) begin
              rsp_data_d = ALU_DATA_WIDTH'(bus.RX_P_DATA);
            end else begin
              rsp_data_d = ALU_DATA_WIDTH'({bus.RX_P_DATA, rx_byte0_q});
            end
            state_d = S_DONE;
          end else begin
            rx_byte0_d = bus.RX_P_DATA;
            rx_cnt_d   = rx_cnt_q + 2'd1;
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          // The current idle cycle is the TIMEOUT_CYCLES-th in a row.
          state_d = S_ABORT;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      type_q     <= CMD_WRITE;
      addr_q     <= '0;
      data_a_q   <= '0;
      data_b_q   <= '0;
      func_q     <= '0;
      rx_cnt_q   <= '0;
      rx_byte0_q <= '0;
      rsp_data_q <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      type_q     <= type_d;
      addr_q     <= addr_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      func_q     <= func_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_byte0_q <= rx_byte0_d;
      rsp_data_q <= rsp_data_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  // Outputs decode straight from the state register, so reset clears them
  // asynchronously together with the state.
  assign bus.CMD_RDY     = (state_q == S_IDLE);
  assign bus.BUSY        = (state_q != S_IDLE);
  assign bus.TX_P_VLD    = (state_q == S_SEND);
  assign bus.TX_P_DATA   = (state_q == S_SEND) ? frame_byte : '0;
  assign bus.RSP_DATA    = rsp_data_q;
  assign bus.RSP_VLD     = (state_q == S_DONE);
  assign bus.RSP_TIMEOUT = (state_q == S_ABORT);

endmodule

// File: tb/tb_sys_cmd_master.sv
// ----------------------------------------------------------------------------
// tb_sys_cmd_master
//   Directed bench for sys_cmd_master with hand-computed expected frames and
//   responses. TIMEOUT_CYCLES is reduced to 8 to keep the abort case short.
// ----------------------------------------------------------------------------
module tb_sys_cmd_master;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  sys_cmd_master_if #(
    .FRAME_WIDTH(8), .REG_FILE_ADDR_WIDTH(4),
    .ALU_FUNC_WIDTH(4), .ALU_DATA_WIDTH(16)
  ) bus ();

  sys_cmd_master #(
    .FRAME_WIDTH(8), .REG_FILE_ADDR_WIDTH(4), .ALU_FUNC_WIDTH(4),
    .ALU_DATA_WIDTH(16), .TIMEOUT_CYCLES(8)
  ) dut (
    .CLK   (clk),
    .RST_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; observe and drive 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic [1:0] t, input logic [3:0] addr,
                           input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] func);
    bus.CMD_VLD    = 1'b1;
    bus.CMD_TYPE   = t;
    bus.CMD_ADDR   = addr;
    bus.CMD_DATA_A = a;
    bus.CMD_DATA_B = b;
    bus.CMD_FUNC   = func;
    tick();
    // Scramble the request after acceptance; the frame must not follow it.
    bus.CMD_VLD    = 1'b0;
    bus.CMD_TYPE   = ~t;
    bus.CMD_ADDR   = 4'hF;
    bus.CMD_DATA_A = 8'hEE;
    bus.CMD_DATA_B = 8'hEE;
    bus.CMD_FUNC   = 4'hF;
  endtask

  // Collects n TX bytes, optionally toggling TX_READY, checking each byte,
  // stability while stalled, and optionally injecting a stray RX pulse in the
  // cycle the last byte is accepted. Returns the cycles spent.
  task automatic tx_expect(input string tag, input logic [7:0] b0,
                           input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input int n,
                           input bit toggle, input bit stray_last,
                           output int cycles);
    logic [7:0] exp [4];
    logic [7:0] held;
    bit         hold;
    int         got;
    exp    = '{b0, b1, b2, b3};
    held   = '0;
    hold   = 1'b0;
    got    = 0;
    cycles = 0;
    while (got < n && cycles < 40) begin
      bus.TX_READY = toggle ? cycles[0] : 1'b1;
      if (bus.TX_P_VLD) begin
        if (hold) check($sformatf("%s_stable%0d", tag, got), bus.TX_P_DATA, held);
        if (bus.TX_READY) begin
          check($sformatf("%s_b%0d", tag, got), bus.TX_P_DATA, exp[got]);
          if (stray_last && got == n - 1) begin
            bus.RX_P_VLD  = 1'b1;
            bus.RX_P_DATA = 8'h99;
          end
          got++;
          hold = 1'b0;
        end else begin
          hold = 1'b1;
          held = bus.TX_P_DATA;
        end
      end
      tick();
      bus.RX_P_VLD = 1'b0;
      cycles++;
    end
    bus.TX_READY = 1'b1;
    check({tag, "_count"}, got, n);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    bus.RX_P_VLD  = 1'b1;
    bus.RX_P_DATA = b;
    tick();
    bus.RX_P_VLD  = 1'b0;
    bus.RX_P_DATA = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    int  n;
    bit  saw_vld;

    rst_n          = 1'b0;
    bus.CMD_VLD    = 1'b0;
    bus.CMD_TYPE   = 2'd0;
    bus.CMD_ADDR   = '0;
    bus.CMD_DATA_A = '0;
    bus.CMD_DATA_B = '0;
    bus.CMD_FUNC   = '0;
    bus.TX_READY   = 1'b1;
    bus.RX_P_DATA  = '0;
    bus.RX_P_VLD   = 1'b0;

    tick();
    tick();
    check("rst_cmd_rdy",     bus.CMD_RDY,     1);
    check("rst_busy",        bus.BUSY,        0);
    check("rst_tx_vld",      bus.TX_P_VLD,    0);
    check("rst_tx_data",     bus.TX_P_DATA,   0);
    check("rst_rsp_data",    bus.RSP_DATA,    0);
    check("rst_rsp_vld",     bus.RSP_VLD,     0);
    check("rst_rsp_timeout", bus.RSP_TIMEOUT, 0);
    rst_n = 1'b1;
    tick();

    // Write reg 5 = 0x3C: bytes at N+1..N+3, RSP_VLD at N+4, CMD_RDY at N+5.
    issue_cmd(2'd0, 4'h5, 8'h3C, 8'h00, 4'h0);
    check("wr_busy", bus.BUSY, 1);
    tx_expect("wr", 8'hAA, 8'h05, 8'h3C, 8'h00, 3, 1'b0, 1'b0, cyc);
    check("wr_tx_cycles", cyc, 3);
    check("wr_rsp_vld",   bus.RSP_VLD,  1);
    check("wr_rsp_data",  bus.RSP_DATA, 16'h0000);
    check("wr_rdy_done",  bus.CMD_RDY,  0);
    check("wr_tx_vld_end", bus.TX_P_VLD, 0);
    tick();
    check("wr_rdy_back",  bus.CMD_RDY,  1);
    check("wr_vld_drop",  bus.RSP_VLD,  0);

    // Read reg 2 with TX_READY toggling; response 0x81.
    issue_cmd(2'd1, 4'h2, 8'h00, 8'h00, 4'h0);
    tx_expect("rd", 8'hBB, 8'h02, 8'h00, 8'h00, 2, 1'b1, 1'b0, cyc);
    tick();
    check("rd_wait_vld", bus.RSP_VLD, 0);
    rx_byte(8'h81);
    check("rd_rsp_vld",  bus.RSP_VLD,  1);
    check("rd_rsp_data", bus.RSP_DATA, 16'h0081);
    tick();
    check("rd_rdy_back", bus.CMD_RDY, 1);

    // ALU with operands: 0x10 + 0x20, response 0x30, 0x00.
    issue_cmd(2'd2, 4'h0, 8'h10, 8'h20, 4'h0);
    tx_expect("alu", 8'hCC, 8'h10, 8'h20, 8'h00, 4, 1'b0, 1'b0, cyc);
    rx_byte(8'h30);
    check("alu_mid_vld", bus.RSP_VLD, 0);
    tick();
    rx_byte(8'h00);
    check("alu_rsp_vld",  bus.RSP_VLD,  1);
    check("alu_rsp_data", bus.RSP_DATA, 16'h0030);
    tick();
    check("alu_rdy_back", bus.CMD_RDY, 1);

    // ALU without operands, func 0xA, no response: abort after 8 idle cycles.
    issue_cmd(2'd3, 4'h0, 8'h00, 8'h00, 4'hA);
    tx_expect("nop", 8'hDD, 8'h0A, 8'h00, 8'h00, 2, 1'b0, 1'b0, cyc);
    n       = 0;
    saw_vld = 1'b0;
    while (!bus.RSP_TIMEOUT && n < 30) begin
      if (bus.RSP_VLD) saw_vld = 1'b1;
      tick();
      n++;
    end
    check("tmo_cycles",    n,            8);
    check("tmo_pulse",     bus.RSP_TIMEOUT, 1);
    check("tmo_no_vld",    saw_vld,      0);
    check("tmo_rsp_hold",  bus.RSP_DATA, 16'h0030);
    check("tmo_rdy_abort", bus.CMD_RDY,  0);
    tick();
    check("tmo_rdy_back",  bus.CMD_RDY,  1);
    check("tmo_pulse_end", bus.RSP_TIMEOUT, 0);

    // Stray RX in IDLE and on the last-TX-accept cycle, then a read of 0x55.
    rx_byte(8'hEE);
    check("stray_idle_rdy", bus.CMD_RDY, 1);
    check("stray_idle_vld", bus.RSP_VLD, 0);
    issue_cmd(2'd1, 4'h7, 8'h00, 8'h00, 4'h0);
    tx_expect("stray", 8'hBB, 8'h07, 8'h00, 8'h00, 2, 1'b0, 1'b1, cyc);
    tick();
    tick();
    check("stray_ignored", bus.RSP_VLD, 0);
    rx_byte(8'h55);
    check("stray_rsp_vld",  bus.RSP_VLD,  1);
    check("stray_rsp_data", bus.RSP_DATA, 16'h0055);
    tick();

    // Reset during SEND after two bytes of a CC frame.
    issue_cmd(2'd2, 4'h0, 8'h11, 8'h22, 4'h3);
    check("rst_b0", bus.TX_P_DATA, 8'hCC);
    tick();
    check("rst_b1", bus.TX_P_DATA, 8'h11);
    tick();
    check("rst_b2", bus.TX_P_DATA, 8'h22);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx_vld",  bus.TX_P_VLD, 0);
    check("rst_mid_rdy",     bus.CMD_RDY,  1);
    check("rst_mid_rsp_vld", bus.RSP_VLD,  0);
    check("rst_mid_data",    bus.RSP_DATA, 16'h0000);
    tick();
    rst_n = 1'b1;
    tick();
    issue_cmd(2'd0, 4'h1, 8'h77, 8'h00, 4'h0);
    tx_expect("post", 8'hAA, 8'h01, 8'h77, 8'h00, 3, 1'b0, 1'b0, cyc);
    check("post_rsp_vld", bus.RSP_VLD, 1);
    tick();
    check("post_rdy", bus.CMD_RDY, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sys_cmd_master.md
# sys_cmd_master

Host-side command initiator for the UART register-file/ALU system: it turns one parallel command request into the system's byte-frame protocol, presents the bytes to a UART transmitter, then collects and assembles the response bytes from a UART receiver. It runs in a single clock domain. Its intended uses are as a bench driver for the system and as the controller in a host FPGA that talks to the system over UART.

## Interface
- FRAME_WIDTH, 8, byte width on the TX/RX interfaces
- REG_FILE_ADDR_WIDTH, 4, register address width
- ALU_FUNC_WIDTH, 4, ALU function code width
- ALU_DATA_WIDTH, 16, response width
- TIMEOUT_CYCLES, 4096, idle cycles in WAIT_RSP before abort (≥2)

Ports:
- CLK  in  1  clock; single domain
- RST_n  in  1  reset, asynchronous, active-low
- CMD_VLD  in  1  command request
- CMD_RDY  out  1  high only in IDLE; a command is accepted when CMD_VLD & CMD_RDY
- CMD_TYPE  in  2  0 = RF write, 1 = RF read, 2 = ALU with operands, 3 = ALU without operands
- CMD_ADDR  in  REG_FILE_ADDR_WIDTH  register address
- CMD_DATA_A  in  8  write data / operand A
- CMD_DATA_B  in  8  operand B
- CMD_FUNC  in  ALU_FUNC_WIDTH  ALU function
- TX_P_DATA  out  8  byte to the transmitter
- TX_P_VLD  out  1  byte valid
- TX_READY  in  1  transmitter ready; a byte is accepted when TX_P_VLD & TX_READY
- RX_P_DATA  in  8  received byte
- RX_P_VLD  in  1  one-cycle pulse per received byte
- RSP_DATA  out  16  assembled response; holds until the next RSP_VLD
- RSP_VLD  out  1  one-cycle completion pulse
- RSP_TIMEOUT  out  1  one-cycle abort pulse
- BUSY  out  1  high whenever the FSM is not in IDLE

## Operation
- Frames (sent in byte order):
  - write: 0xAA, addr, data
  - read: 0xBB, addr
  - ALU with operands: 0xCC, A, B, func
  - ALU without operands: 0xDD, func
  - addr and func are zero-extended to 8 bits.
- Response byte count: write 0; read 1; ALU 2, LSB first.
- Response assembly:
  - read: RSP_DATA = {8'h00, byte}
  - ALU: RSP_DATA = {byte1, byte0}
  - write: RSP_DATA = 16'h0000.
- On acceptance, CMD_TYPE/ADDR/DATA_A/DATA_B/FUNC are registered. Inputs may change afterwards without effect.
- FSM states:
  - IDLE: CMD_RDY = 1. Command acceptance → SEND with byte index 0.
  - SEND: TX_P_VLD = 1 and TX_P_DATA = frame[idx]. Both hold stable until accepted. On accept, idx increments. On accepting the last byte: → WAIT_RSP if the response count > 0, otherwise → DONE.
  - WAIT_RSP: each RX_P_VLD stores a byte and increments the RX count. When the final byte is stored → DONE. After TIMEOUT_CYCLES consecutive cycles without RX_P_VLD → ABORT.
  - DONE: pulses RSP_VLD with RSP_DATA valid → IDLE.
  - ABORT: pulses RSP_TIMEOUT. RSP_DATA is unchanged. → IDLE.
- The timeout counter clears on entry to WAIT_RSP and on every RX_P_VLD. It saturates and is used only in WAIT_RSP.
- RX_P_VLD outside WAIT_RSP is discarded, including in the cycle the last TX byte is accepted.
- A new command is never accepted in the DONE or ABORT cycle.
- Reset (asynchronous, any state) aborts any frame in progress immediately. No partial response is reported.

## Timing
- Reset values:
  - state IDLE
  - CMD_RDY = 1
  - TX_P_VLD = 0, TX_P_DATA = 0x00
  - RSP_DATA = 0x0000
  - RSP_VLD = 0, RSP_TIMEOUT = 0
  - BUSY = 0
  - all counters 0
- Command accepted at cycle N: TX_P_VLD = 1 with the opcode at N+1. With TX_READY held high, one byte is accepted per cycle and TX_P_VLD stays high through the last byte.
- Write with TX_READY always high: bytes are accepted at N+1..N+3, RSP_VLD = 1 at N+4, and CMD_RDY = 1 at N+5.
- Final RX byte at cycle M: RSP_VLD = 1 at M+1, and CMD_RDY = 1 at M+2.
- Timeout: RSP_TIMEOUT = 1 on the cycle after the TIMEOUT_CYCLES-th consecutive idle cycle in WAIT_RSP.
- BUSY = ~CMD_RDY at all times.

## Test plan
- Write reg 5 = 0x3C with TX_READY = 1 → TX bytes 0xAA, 0x05, 0x3C on consecutive cycles; RSP_VLD with RSP_DATA = 0x0000 four cycles after acceptance.
- Read reg 2 while TX_READY toggles every other cycle; RX returns 0x81 → TX_P_DATA stable while not accepted; TX bytes 0xBB, 0x02; RSP_DATA = 0x0081 one cycle after RX_P_VLD.
- ALU with A = 0x10, B = 0x20, func = 0; RX returns 0x30 then 0x00 → TX bytes 0xCC, 0x10, 0x20, 0x00; RSP_DATA = 0x0030.
- ALU without operands, func = 0xA; no RX bytes, TIMEOUT_CYCLES = 8 → TX bytes 0xDD, 0x0A; RSP_TIMEOUT pulses after 8 idle cycles, RSP_VLD stays 0; CMD_RDY returns to 1.
- Stray RX_P_VLD while IDLE and on the last-TX-accept cycle, then a read that returns 0x55 → stray bytes ignored; RSP_DATA = 0x0055.
- RST_n asserted mid-SEND after byte 2 of a 0xCC frame → TX_P_VLD = 0 and CMD_RDY = 1 immediately; the next command starts with its own opcode.
